// File: rtl/serial_rx_fifo_pkg.sv
// Shared definitions for the 8N1 serial receiver: frame geometry,
// oversampling constants and receiver FSM state encodings.
package serial_rx_fifo_pkg;

  localparam int BITS       = 8;
  localparam int OVERSAMPLE = 4;
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W      = $clog2(BITS);

  // Mid start bit is two ticks after the edge was seen; later bits are one full period apart.
  localparam logic [TICK_W-1:0] START_SAMPLE_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK         = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT          = BIT_W'(BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/serial_rx_fifo_fifo.sv
// Byte FIFO with combinational head output; NUM must be a power of two >= 2.
// Writes when full and reads when empty are ignored.
module serial_rx_fifo_fifo
  import serial_rx_fifo_pkg::*;
#(
  parameter int NUM = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write_strobe,
  input  logic [BITS-1:0] write_data,
  input  logic            read_strobe,
  output logic [BITS-1:0] read_data,
  output logic            data_available,
  output logic            space_available
);

  localparam int AW = $clog2(NUM);

  logic [BITS-1:0] mem_q [NUM];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_write, do_read;

  assign data_available  = (count_q != '0);
  assign space_available = (count_q != (AW + 1)'(NUM));
  assign do_write        = write_strobe & space_available;
  assign do_read         = read_strobe & data_available;
  assign read_data       = mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_read)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_write, do_read})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= write_data;
  end

endmodule

// File: rtl/serial_rx_fifo.sv
// 8N1 serial receiver oversampled by a baud_x4 strobe, feeding a byte FIFO.
// Overflow and framing errors are reported as sticky flags.
module serial_rx_fifo
  import serial_rx_fifo_pkg::*;
#(
  parameter int NUM = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            baud_x4,
  input  logic            serial,
  output logic [BITS-1:0] read_data,
  input  logic            read_strobe,
  output logic            data_available,
  output logic            overflow,
  output logic            framing_error,
  input  logic            error_clear
);

  rx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [BITS-1:0]   shift_q, shift_d;
  logic              push_q, push_d;
  logic              overflow_q, overflow_d;
  logic              framing_error_q, framing_error_d;
  logic              rx_meta_q, rx_s_q;
  logic              space_available;
  logic              stop_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= ST_IDLE;
      tick_q          <= '0;
      bit_q           <= '0;
      shift_q         <= '0;
      push_q          <= 1'b0;
      overflow_q      <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      rx_meta_q       <= serial;
      rx_s_q          <= rx_meta_q;
      state_q         <= state_d;
      tick_q          <= tick_d;
      bit_q           <= bit_d;
      shift_q         <= shift_d;
      push_q          <= push_d;
      overflow_q      <= overflow_d;
      framing_error_q <= framing_error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (baud_x4) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d = ST_START;
            tick_d  = '0;
          end
        end
        ST_START: begin
          if (tick_q == START_SAMPLE_TICK) begin
            // A line back high at mid start bit was only a glitch.
            if (rx_s_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              bit_d   = '0;
              tick_d  = '0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_DATA: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == LAST_TICK) begin
            shift_d = {rx_s_q, shift_q[BITS-1:1]};
            tick_d  = '0;
            if (bit_q == LAST_BIT) state_d = ST_STOP;
            else                   bit_d   = bit_q + 1'b1;
          end
        end
        ST_STOP: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            state_d = rx_s_q ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          // Hold off until the line returns high so a held-low line never restarts a frame.
          if (rx_s_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stop_tick       = baud_x4 && (state_q == ST_STOP) && (tick_q == LAST_TICK);
    push_d          = stop_tick & rx_s_q;
    // A new error in the same cycle as error_clear keeps the flag set.
    overflow_d      = (overflow_q & ~error_clear) | (push_q & ~space_available);
    framing_error_d = (framing_error_q & ~error_clear) | (stop_tick & ~rx_s_q);
  end

  assign overflow      = overflow_q;
  assign framing_error = framing_error_q;

  serial_rx_fifo_fifo #(.NUM(NUM)) u_fifo (
    .clk             (clk),
    .reset           (reset),
    .write_strobe    (push_q & space_available),
    .write_data      (shift_q),
    .read_strobe     (read_strobe & data_available),
    .read_data       (read_data),
    .data_available  (data_available),
    .space_available (space_available)
  );

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Self-checking bench for serial_rx_fifo: table-driven byte frames plus
// hand-written overflow, framing, glitch, reset and read-while-empty sequences.
module tb_serial_rx_fifo;

  localparam int NUM     = 64;
  localparam int BIT_CLK = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_x4 = 1'b0;
  logic       serial;
  logic [7:0] read_data;
  logic       read_strobe;
  logic       data_available;
  logic       overflow;
  logic       framing_error;
  logic       error_clear;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic       exp_ovf;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_store;
  } vec_t;

  vec_t vecs [6];

  serial_rx_fifo #(.NUM(NUM)) dut (
    .clk            (clk),
    .reset          (reset),
    .baud_x4        (baud_x4),
    .serial         (serial),
    .read_data      (read_data),
    .read_strobe    (read_strobe),
    .data_available (data_available),
    .overflow       (overflow),
    .framing_error  (framing_error),
    .error_clear    (error_clear)
  );

  always #5 clk = ~clk;

  // baud_x4: one-clk pulse every 8 clk.
  int baud_cnt = 0;
  always @(posedge clk) begin
    #1;
    baud_cnt = (baud_cnt == 7) ? 0 : baud_cnt + 1;
    baud_x4  = (baud_cnt == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    serial = b;
    tick(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  // Send a good frame and update the FIFO model.
  task automatic send_good(input logic [7:0] d);
    send_frame(d, 1'b1);
    if (exp_q.size() < NUM) exp_q.push_back(d);
    else                    exp_ovf = 1'b1;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    logic [7:0] exp;
    while (exp_q.size() > 0 && guard < 4000) begin
      if (data_available) begin
        exp = exp_q.pop_front();
        check({name, " byte"}, {24'd0, read_data}, {24'd0, exp});
        read_strobe = 1'b1;
        tick(1);
        read_strobe = 1'b0;
      end else begin
        tick(1);
        guard++;
      end
    end
    if (exp_q.size() > 0) begin
      check({name, " timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    check({name, " empty"}, {31'd0, data_available}, 32'd0);
  endtask

  task automatic pulse_clear();
    error_clear = 1'b1;
    tick(1);
    error_clear = 1'b0;
    tick(1);
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b1};
    vecs[1] = '{8'hA3, 1'b1, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1};
    vecs[4] = '{8'h99, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 1'b1};

    reset = 1'b1; serial = 1'b1; read_strobe = 1'b0; error_clear = 1'b0; exp_ovf = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(2);
    check("reset data_available", {31'd0, data_available}, 32'd0);
    check("reset overflow",       {31'd0, overflow},       32'd0);
    check("reset framing_error",  {31'd0, framing_error},  32'd0);

    // Back-to-back good bytes.
    for (int i = 0; i < 4; i++) send_good(vecs[i].data);
    tick(BIT_CLK * 2);
    drain("burst");
    check("burst overflow",      {31'd0, overflow},      32'd0);
    check("burst framing_error", {31'd0, framing_error}, 32'd0);

    // Table with a bad stop bit in the middle; the line idles high between frames.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_bit);
      if (vecs[i].exp_store) exp_q.push_back(vecs[i].data);
      serial = 1'b1;
      tick(BIT_CLK * 2);
    end
    drain("table");
    check("table framing_error", {31'd0, framing_error}, 32'd1);
    pulse_clear();
    check("table fe cleared", {31'd0, framing_error}, 32'd0);

    // Overflow: NUM+2 bytes with no reads.
    exp_ovf = 1'b0;
    for (int i = 0; i < NUM + 2; i++) send_good(8'(i));
    tick(BIT_CLK * 2);
    check("ovf overflow",      {31'd0, overflow},      {31'd0, exp_ovf});
    check("ovf framing_error", {31'd0, framing_error}, 32'd0);
    drain("ovf");
    pulse_clear();
    check("ovf cleared", {31'd0, overflow}, 32'd0);

    // Framing error, long break, then a good byte.
    send_frame(8'h12, 1'b0);
    serial = 1'b0;
    tick(BIT_CLK * 100);
    serial = 1'b1;
    tick(BIT_CLK * 2);
    send_good(8'h34);
    tick(BIT_CLK * 2);
    check("break framing_error", {31'd0, framing_error}, 32'd1);
    check("break overflow",      {31'd0, overflow},      32'd0);
    drain("break");
    pulse_clear();
    check("break fe cleared", {31'd0, framing_error}, 32'd0);

    // 8-clk low glitch on an idle line.
    serial = 1'b0;
    tick(8);
    serial = 1'b1;
    tick(BIT_CLK * 4);
    check("glitch data_available", {31'd0, data_available}, 32'd0);
    check("glitch framing_error",  {31'd0, framing_error},  32'd0);
    check("glitch overflow",       {31'd0, overflow},       32'd0);

    // Reset in the middle of bit 4 of 0x7E, then 0x81.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0 ^ ((8'h7E >> i) & 8'h01) != 0);
    serial = 1'b1;
    tick(BIT_CLK / 2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("midreset data_available", {31'd0, data_available}, 32'd0);
    tick(BIT_CLK * 2);
    exp_q.delete();
    send_good(8'h81);
    tick(BIT_CLK * 2);
    drain("midreset");

    // read_strobe held high while empty, then 0x5A arrives.
    begin
      int guard = 0;
      read_strobe = 1'b1;
      tick(16);
      check("hold empty data_available", {31'd0, data_available}, 32'd0);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(((8'h5A >> i) & 8'h01) != 0);
      serial = 1'b1;
      while (!data_available && guard < 200) begin
        tick(1);
        guard++;
      end
      check("hold rise seen", {31'd0, data_available}, 32'd1);
      check("hold read_data", {24'd0, read_data}, 32'h5A);
      tick(1);
      check("hold popped", {31'd0, data_available}, 32'd0);
      read_strobe = 1'b0;
      tick(BIT_CLK);
      check("hold still empty",    {31'd0, data_available}, 32'd0);
      check("hold framing_error",  {31'd0, framing_error},  32'd0);
      check("hold overflow",       {31'd0, overflow},       32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
